// File: rtl/analog_dir_decoder.sv
// Analog/digital joystick to filtered {up,down,left,right} direction with per-axis hysteresis.
// Define ANALOG_DIAG_EN for 8-way output; default build locks to 4-way.
module analog_dir_decoder #(
    parameter int unsigned DZ_ON      = 48,
    parameter int unsigned DZ_OFF     = 32,
    parameter int unsigned FILTER_CNT = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_sample,
    input  logic [15:0] joy_analog,
    input  logic [3:0]  joy_digital,
    input  logic        sel_analog,
    output logic [3:0]  dir,
    output logic        dir_changed
);

    localparam int unsigned MAG_W = 7;
    localparam int unsigned CNT_W = 8;

    localparam logic [MAG_W-1:0] MAG_MAX = 7'd127;
    localparam logic [MAG_W-1:0] ON_TH   = MAG_W'(DZ_ON);
    localparam logic [MAG_W-1:0] OFF_TH  = MAG_W'(DZ_OFF);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(FILTER_CNT);

    localparam logic [1:0] ST_CENTER = 2'd0;
    localparam logic [1:0] ST_POS    = 2'd1;
    localparam logic [1:0] ST_NEG    = 2'd2;

    logic [1:0]       x_st, y_st, x_st_nxt, y_st_nxt;
    logic [MAG_W-1:0] x_mag, y_mag;
    logic [MAG_W-1:0] x_mag_c, y_mag_c;
    logic [3:0]       dig_q;
    logic [3:0]       pending, pending_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [3:0]       dir_nxt;
    logic             load_c;
    logic [1:0]       horiz_c, vert_c;
    logic [MAG_W-1:0] mag_h_c, mag_v_c;
    logic [3:0]       cand_c;

    // |v| saturated so that -128 reads as 127
    function automatic logic [MAG_W-1:0] mag_of(input logic [7:0] v);
        logic [7:0] a;
        a = v[7] ? (8'd0 - v) : v;
        return a[7] ? MAG_MAX : a[MAG_W-1:0];
    endfunction

    // Hysteretic axis: a strong opposite deflection jumps straight across centre
    function automatic logic [1:0] axis_next(input logic [1:0] st, input logic neg,
                                             input logic [MAG_W-1:0] mag);
        logic [1:0] nxt;
        nxt = st;
        if (mag >= ON_TH) begin
            nxt = neg ? ST_NEG : ST_POS;
        end else begin
            case (st)
                ST_POS:    if (neg || (mag < OFF_TH)) nxt = ST_CENTER;
                ST_NEG:    if (!neg || (mag < OFF_TH)) nxt = ST_CENTER;
                default:   nxt = ST_CENTER;
            endcase
        end
        return nxt;
    endfunction

    assign x_mag_c = mag_of(joy_analog[7:0]);
    assign y_mag_c = mag_of(joy_analog[15:8]);

    // Raw per-axis direction from the selected source
    always_comb begin
        horiz_c = 2'b00;
        vert_c  = 2'b00;
        mag_h_c = MAG_MAX;
        mag_v_c = MAG_MAX;
        if (sel_analog) begin
            horiz_c = {x_st == ST_NEG, x_st == ST_POS};
            vert_c  = {y_st == ST_NEG, y_st == ST_POS};
            mag_h_c = x_mag;
            mag_v_c = y_mag;
        end else begin
            horiz_c = (&dig_q[1:0]) ? 2'b00 : dig_q[1:0];
            vert_c  = (&dig_q[3:2]) ? 2'b00 : dig_q[3:2];
        end
    end

    // Candidate; in 4-way mode the stronger axis wins, ties keep the displayed axis
    always_comb begin
`ifdef ANALOG_DIAG_EN
        cand_c = {vert_c, horiz_c};
`else
        cand_c = {vert_c, horiz_c};
        if ((|horiz_c) && (|vert_c)) begin
            if (mag_h_c > mag_v_c) begin
                cand_c = {2'b00, horiz_c};
            end else if (mag_v_c > mag_h_c) begin
                cand_c = {vert_c, 2'b00};
            end else if (|dir[3:2]) begin
                cand_c = {vert_c, 2'b00};
            end else begin
                cand_c = {2'b00, horiz_c};
            end
        end
`endif
    end

    // Next-state for axes and the persistence filter
    always_comb begin
        x_st_nxt    = x_st;
        y_st_nxt    = y_st;
        pending_nxt = pending;
        count_nxt   = count;
        dir_nxt     = dir;
        load_c      = 1'b0;
        if (ce_sample) begin
            x_st_nxt = axis_next(x_st, joy_analog[7], x_mag_c);
            y_st_nxt = axis_next(y_st, joy_analog[15], y_mag_c);
            if (cand_c != pending) begin
                pending_nxt = cand_c;
                count_nxt   = CNT_W'(1);
            end else if (count != CNT_TGT) begin
                count_nxt = count + CNT_W'(1);
            end
            if ((count_nxt == CNT_TGT) && (pending_nxt != dir)) begin
                dir_nxt = pending_nxt;
                load_c  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            x_st        <= ST_CENTER;
            y_st        <= ST_CENTER;
            x_mag       <= '0;
            y_mag       <= '0;
            dig_q       <= '0;
            pending     <= '0;
            count       <= '0;
            dir         <= '0;
            dir_changed <= 1'b0;
        end else begin
            x_st        <= x_st_nxt;
            y_st        <= y_st_nxt;
            pending     <= pending_nxt;
            count       <= count_nxt;
            dir         <= dir_nxt;
            dir_changed <= load_c;
            if (ce_sample) begin
                x_mag <= x_mag_c;
                y_mag <= y_mag_c;
                dig_q <= joy_digital;
            end
        end
    end

endmodule

// File: doc/analog_dir_decoder.md
ANALOG_DIR_DECODER -- requirements
Module: analog_dir_decoder

Interface
REQ-001 Parameter: DZ_ON, default 48, unsigned 7-bit magnitude at or above which an axis leaves centre.
REQ-002 Parameter: DZ_OFF, default 32, magnitude below which an active axis returns to centre; DZ_OFF < DZ_ON.
REQ-003 Parameter: FILTER_CNT, default 3, range 1..255, consecutive equal samples required before the output changes.
REQ-004 clk_sys  input  1  system clock; all state rises on its positive edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ce_sample  input  1  sample strobe, one clk_sys wide; all state advances only on it.
REQ-007 joy_analog  input  16  [7:0] signed X (negative = left), [15:8] signed Y (negative = up).
REQ-008 joy_digital  input  4  {up,down,left,right} digital direction, active high.
REQ-009 sel_analog  input  1  1 = analog source, 0 = digital source.
REQ-010 dir  output  4  filtered {up,down,left,right} to the williams2 run/aim port.
REQ-011 dir_changed  output  1  one-cycle pulse when dir updates.

Function
REQ-012 Magnitude per axis SHALL be |v| saturated to 127 (-128 -> 127), 7-bit unsigned.
REQ-013 Each axis SHALL be a 3-state FSM: CENTER, POS, NEG, updated on ce_sample.
REQ-014 CENTER->POS when v >= 0 and mag >= DZ_ON; CENTER->NEG when v < 0 and mag >= DZ_ON.
REQ-015 POS->NEG directly when v < 0 and mag >= DZ_ON; else POS->CENTER when v < 0 or mag < DZ_OFF; NEG symmetric.
REQ-016 Analog raw direction: right = X POS, left = X NEG, down = Y POS, up = Y NEG; left and right never both set, same for up/down.
REQ-017 Digital raw direction SHALL be joy_digital registered on ce_sample; opposing pairs both set -> that pair cleared.
REQ-018 Candidate SHALL be the analog or digital raw direction per sel_analog, sampled combinationally at each ce_sample.
REQ-019 Filter: candidate != pending -> pending <= candidate, count <= 1; else count increments, saturating at FILTER_CNT.
REQ-020 dir SHALL load pending on the ce_sample where count reaches FILTER_CNT (including count 1 with FILTER_CNT=1), only if different.
REQ-021 dir_changed SHALL be 1 for exactly the clk_sys cycle after dir loads, else 0.
REQ-022 Latency: input held before ce_sample pulse k updates dir after pulse k+FILTER_CNT (axis register adds one pulse).
REQ-023 A candidate toggling before count reaches FILTER_CNT SHALL leave dir unchanged (glitch rejection).
REQ-024 sel_analog switching SHALL be treated as an ordinary candidate change, no extra reset of axis FSMs.
REQ-025 ce_sample low: no state, counter or output changes; dir_changed still clears after its single cycle.

Reset
REQ-026 reset_n low SHALL asynchronously set both axis FSMs to CENTER, digital register, pending and dir to 0, count to 0, dir_changed to 0.
REQ-027 Reset mid-filtering SHALL discard pending; first candidate after release restarts counting from 1.
REQ-028 Release is synchronous to clk_sys by the enclosing top; no internal synchroniser.

Configuration
REQ-029 Macro ANALOG_DIAG_EN defined: candidate may carry one horizontal and one vertical bit simultaneously (8-way).
REQ-030 ANALOG_DIAG_EN undefined: 4-way lock; if both axes active, keep only the axis with larger magnitude; on tie keep the axis dir currently shows, else horizontal.
REQ-031 4-way lock SHALL apply to both analog and digital sources; magnitude of a digital bit is 127.

Verification
REQ-032 FILTER_CNT=3, X=+60 held from pulse 0 -> dir=4'b0001 after pulse 3, dir_changed one cycle, dir 0 before.
REQ-033 Hysteresis: X=+60 then +40 -> stays right; X=+20 -> dir=0 after 3 pulses; X=-128 from right -> left directly, mag 127.
REQ-034 Glitch: X=+60 for 2 pulses, then 0 -> dir never changes, dir_changed never pulses.
REQ-035 Without ANALOG_DIAG_EN: X=+100,Y=-60 -> 4'b0001; X=+60,Y=-100 -> 4'b1000; with macro X=+100,Y=-60 -> 4'b1001.
REQ-036 sel_analog=0, joy_digital=4'b0011 -> dir=0; 4'b1000 -> 4'b1000 after 3 pulses.
REQ-037 reset_n low mid-count (count=2) -> dir=0 immediately, no clock needed; after release needs full 3 pulses.
